// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared FSM states and fetch constants for the instruction fetch stage
package ifu_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} ifu_state_e;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] ADDR_INIT = 32'h8000_0000;
  localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: redirect, instruction-memory and ifu2idu handshake signals of the fetch stage
interface ifu_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bru_jmp_en;
  logic [ADDR_WIDTH-1:0] bru_jmp_pc;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  mem_rsp_ready;
  logic                  sys_valid;
  logic                  sys_ready;
  logic [ADDR_WIDTH-1:0] ifu_pc;
  logic [ADDR_WIDTH-1:0] ifu_pc_next;
  logic [DATA_WIDTH-1:0] ifu_inst;
  modport master (
    input  bru_jmp_en, bru_jmp_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, sys_ready,
    output mem_req_valid, mem_req_addr, mem_rsp_ready, sys_valid, ifu_pc, ifu_pc_next, ifu_inst
  );
  modport slave (
    output bru_jmp_en, bru_jmp_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, sys_ready,
    input  mem_req_valid, mem_req_addr, mem_rsp_ready, sys_valid, ifu_pc, ifu_pc_next, ifu_inst
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch FSM with redirect flush and held ifu2idu outputs
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = ifu_pkg::ADDR_INIT,
  parameter logic [DATA_WIDTH-1:0] INST_NOP   = ifu_pkg::INST_NOP
) (
  input logic         i_sys_clk,
  input logic         i_sys_rst,
  ifu_fetch_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, out_pc_q, out_pc_next_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  cap;
  logic                  jmp;
  logic                  req_hs;
  logic                  rsp;
  assign jmp    = bus.bru_jmp_en;
  assign req_hs = (state_q == REQ) && bus.mem_req_ready;
  assign rsp    = bus.mem_rsp_valid;
  // Redirect wins over every other event; a response racing a redirect is consumed but discarded.
  always_comb begin
    state_d = state_q;
    pc_d    = jmp ? bus.bru_jmp_pc : pc_q;
    cap     = 1'b0;
    case (state_q)
      REQ:  state_d = req_hs ? (jmp ? DROP : WAIT) : REQ;
      WAIT: begin
        state_d = jmp ? (rsp ? REQ : DROP) : (rsp ? HOLD : WAIT);
        cap     = !jmp && rsp;
        pc_d    = cap ? pc_q + STEP : pc_d;
      end
      HOLD: state_d = (jmp || bus.sys_ready) ? REQ : HOLD;
      DROP: state_d = rsp ? REQ : DROP;
      default: state_d = REQ;
    endcase
  end
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q       <= REQ;
      pc_q          <= ADDR_INIT;
      out_pc_q      <= ADDR_INIT;
      out_pc_next_q <= ADDR_INIT;
      inst_q        <= INST_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (cap) begin
        out_pc_q      <= pc_q;
        out_pc_next_q <= pc_q + STEP;
        inst_q        <= bus.mem_rsp_data;
      end
    end
  end
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = pc_q;
  assign bus.mem_rsp_ready = (state_q == WAIT) || (state_q == DROP);
  assign bus.sys_valid     = (state_q == HOLD);
  assign bus.ifu_pc        = out_pc_q;
  assign bus.ifu_pc_next   = out_pc_next_q;
  assign bus.ifu_inst      = inst_q;
endmodule
